// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and encodings for the byte-serial memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_e;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam logic [1:0] IO_ADDR_TAG = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter; the port after the last winner
//            gets top priority once adv_i confirms the grant was taken.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 adv_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    // First pass covers ports at or above the pointer, second pass wraps.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_q))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        ptr_d    = (i == NUM_PORTS - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_i[i] && (i < int'(ptr_q))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        ptr_d    = (i == NUM_PORTS - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_arb
// Purpose  : N-port round-robin byte-serial memory controller with read
//            extension, IO stall and flush. Optional: MEM_CTRL_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
#(
  parameter int                   NUM_PORTS  = 2,
  parameter int                   MAX_BYTES  = 4,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 2'b11
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           rob_clear,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS-1:0]           req_signed,
  input  logic [3*NUM_PORTS-1:0]         req_size,
  input  logic [32*NUM_PORTS-1:0]        req_addr,
  input  logic [8*MAX_BYTES*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           resp_valid,
  output logic [8*MAX_BYTES-1:0]         resp_data,
  input  logic [7:0]                     mem_din,
  output logic [7:0]                     mem_dout,
  output logic [31:0]                    mem_a,
  output logic                           mem_wr,
  input  logic                           io_buffer_full
`ifdef MEM_CTRL_ARB_PERF_EN
  ,
  output logic [31:0]                    perf_busy_cycles,
  output logic [31:0]                    perf_io_stall_cycles
`endif
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int LOG2MB = $clog2(MAX_BYTES);
  localparam int KW     = (MAX_BYTES > 1) ? LOG2MB : 1;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         port_q, port_d;
  logic                  write_q, write_d, signed_q, signed_d, io_q, io_d;
  logic                  cap_q, cap_d;
  logic [2:0]            size_q, size_d;
  logic [KW-1:0]         k_q, k_d, cidx_q, cidx_d;
  logic [31:0]           mem_a_q, mem_a_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d, resp_data_q, resp_data_d;
  logic [NUM_PORTS-1:0]  resp_valid_q, resp_valid_d;

  logic [NUM_PORTS-1:0]  elig, gnt, port_oh;
  logic                  sel_write, sel_signed, can_accept, accept, stall, flush_now, last;
  logic [2:0]            sel_size;
  logic [31:0]           sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [PW-1:0]         sel_port;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [2:0] sz, input logic sgn_en);
    logic [DATA_W-1:0] r;
    logic              sgn;
    int                nb;
    r   = raw;
    sgn = 1'b0;
    nb  = 1 << sz;
    for (int b = 0; b < MAX_BYTES; b++) if (b == nb - 1) sgn = raw[8*b+7];
    for (int b = 0; b < MAX_BYTES; b++) if (b >= nb) r[8*b +: 8] = {8{sgn & sgn_en}};
    return r;
  endfunction

  // Flushable reads are held off the arbiter while the pipeline is flushing.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = req_valid[i] && !(rob_clear && !req_write[i] && FLUSH_MASK[i]);
    end
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .adv_i (accept),
    .req_i (elig),
    .gnt_o (gnt)
  );

  always_comb begin
    sel_write  = 1'b0;
    sel_signed = 1'b0;
    sel_size   = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_port   = '0;
    port_oh    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        sel_write  = req_write[i];
        sel_signed = req_signed[i];
        sel_size   = req_size[3*i +: 3];
        sel_addr   = req_addr[32*i +: 32];
        sel_wdata  = req_wdata[DATA_W*i +: DATA_W];
        sel_port   = PW'(i);
      end
      port_oh[i] = (port_q == PW'(i));
    end
  end

  assign can_accept = rdy_in && (state_q == IDLE) && !(|resp_valid_q);
  assign accept     = can_accept && (|gnt);
  assign stall      = (state_q == RUN) && io_q && io_buffer_full;
  assign flush_now  = rob_clear && !write_q && (|(FLUSH_MASK & port_oh));
  assign last       = (k_q == KW'((32'd1 << size_q) - 32'd1));

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    write_d      = write_q;
    signed_d     = signed_q;
    io_d         = io_q;
    size_d       = size_q;
    k_d          = k_q;
    cidx_d       = cidx_q;
    cap_d        = 1'b0;
    mem_a_d      = mem_a_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;

    // A byte issued last cycle is on mem_din now.
    if (cap_q) begin
      for (int b = 0; b < MAX_BYTES; b++) begin
        if (KW'(b) == cidx_q) rdata_d[8*b +: 8] = mem_din;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          port_d   = sel_port;
          write_d  = sel_write;
          signed_d = sel_signed;
          io_d     = (sel_addr[17:16] == IO_ADDR_TAG);
          size_d   = (sel_size > 3'(LOG2MB)) ? 3'(LOG2MB) : sel_size;
          k_d      = '0;
          mem_a_d  = sel_addr;
          wdata_d  = sel_wdata;
          rdata_d  = '0;
        end
      end
      RUN: begin
        if (flush_now) begin
          state_d = IDLE;
        end else if (!stall) begin
          cap_d   = !write_q;
          cidx_d  = k_q;
          k_d     = k_q + KW'(1);
          mem_a_d = mem_a_q + 32'd1;
          wdata_d = wdata_q >> 8;
          if (last) begin
            if (write_q) begin
              state_d      = IDLE;
              resp_valid_d = port_oh;
            end else begin
              state_d = TAIL;
            end
          end
        end
      end
      TAIL: begin
        state_d = IDLE;
        if (!flush_now) begin
          resp_valid_d = port_oh;
          resp_data_d  = extend(rdata_d, size_q, signed_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      port_q       <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      io_q         <= 1'b0;
      size_q       <= '0;
      k_q          <= '0;
      cidx_q       <= '0;
      cap_q        <= 1'b0;
      mem_a_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      // The completion pulse must not repeat across a frozen cycle.
      resp_valid_q <= rdy_in ? resp_valid_d : '0;
      if (rdy_in) begin
        state_q     <= state_d;
        port_q      <= port_d;
        write_q     <= write_d;
        signed_q    <= signed_d;
        io_q        <= io_d;
        size_q      <= size_d;
        k_q         <= k_d;
        cidx_q      <= cidx_d;
        cap_q       <= cap_d;
        mem_a_q     <= mem_a_d;
        wdata_q     <= wdata_d;
        rdata_q     <= rdata_d;
        resp_data_q <= resp_data_d;
      end
    end
  end

  assign req_ready  = gnt & {NUM_PORTS{can_accept}};
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = wdata_q[7:0];
  assign mem_wr     = (state_q == RUN) && write_q && !stall && rdy_in;

`ifdef MEM_CTRL_ARB_PERF_EN
  logic [31:0] busy_q, io_stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      io_stall_q <= '0;
    end else begin
      if (rdy_in && (state_q != IDLE)) busy_q <= busy_q + 32'd1;
      if (rdy_in && stall) io_stall_q <= io_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles     = busy_q;
  assign perf_io_stall_cycles = io_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_arb
// Purpose  : Directed self-checking bench for mem_ctrl_arb with a small RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arb;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [1:0]  req_valid = '0, req_write = '0, req_signed = '0;
  logic [5:0]  req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_data, mem_a;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr;
`ifdef MEM_CTRL_ARB_PERF_EN
  logic [31:0] perf_busy_cycles, perf_io_stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ram [0:4095];

  mem_ctrl_arb dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_clear      (rob_clear),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_signed     (req_signed),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
`ifdef MEM_CTRL_ARB_PERF_EN
    ,
    .perf_busy_cycles     (perf_busy_cycles),
    .perf_io_stall_cycles (perf_io_stall_cycles)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM with one cycle of read latency.
  always @(posedge clk_in) begin
    if (rst_in) ram[12'h100] <= 8'h80;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic p, input logic w, input logic s, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      req_valid[1] = 1'b1; req_write[1] = w; req_signed[1] = s;
      req_size[5:3] = sz; req_addr[63:32] = a; req_wdata[63:32] = d;
    end else begin
      req_valid[0] = 1'b1; req_write[0] = w; req_signed[0] = s;
      req_size[2:0] = sz; req_addr[31:0] = a; req_wdata[31:0] = d;
    end
  endtask

  task automatic clr_req(input logic p);
    if (p) req_valid[1] = 1'b0;
    else   req_valid[0] = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      tick(); settle(); n++;
    end
    chk(tag, 32'(req_ready), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic        any_rv;

    // Reset state
    tick(); tick(); settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rvalid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_data, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_dout", 32'(mem_dout), 32'h0);
    chk("rst_wr", 32'(mem_wr), 32'h0);
    tick(); rst_in = 1'b0; settle();

    // Port0 signed byte read of 0x80 at 0x100
    tick(); set_req(1'b0, 1'b0, 1'b1, SZ_B, 32'h100, 32'h0); settle();
    chk("rdb_ready", 32'(req_ready), 32'h1);
    tick(); clr_req(1'b0); settle();
    chk("rdb_a", mem_a, 32'h100);
    chk("rdb_wr", 32'(mem_wr), 32'h0);
    tick(); settle();
    chk("rdb_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("rdb_rv", 32'(resp_valid), 32'h1);
    chk("rdb_data", resp_data, 32'hFFFFFF80);

    // Port1 word write 0xDEADBEEF at 0x200
    wd = 32'hDEADBEEF;
    tick(); set_req(1'b1, 1'b1, 1'b0, SZ_W, 32'h200, wd); settle();
    chk("wrw_ready", 32'(req_ready), 32'h2);
    for (int j = 0; j < 4; j++) begin
      tick(); clr_req(1'b1); settle();
      chk("wrw_a", mem_a, 32'h200 + 32'(j));
      chk("wrw_dout", 32'(mem_dout), 32'(wd[8*j +: 8]));
      chk("wrw_wr", 32'(mem_wr), 32'h1);
    end
    chk("wrw_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("wrw_rv", 32'(resp_valid), 32'h2);

    // Both ports requesting: grants alternate 0,1,0,1
    tick();
    set_req(1'b0, 1'b1, 1'b0, SZ_B, 32'h400, 32'hA0);
    set_req(1'b1, 1'b1, 1'b0, SZ_B, 32'h401, 32'hB1);
    settle();
    wait_grant("rr_g0", 2'b01);
    tick(); settle(); wait_grant("rr_g1", 2'b10);
    tick(); settle(); wait_grant("rr_g2", 2'b01);
    tick(); settle(); wait_grant("rr_g3", 2'b10);
    tick(); clr_req(1'b0); clr_req(1'b1); settle();
    tick(); settle();
    chk("rr_last_rv", 32'(resp_valid), 32'h2);

    // IO byte write with the UART buffer full for 3 cycles
    tick(); set_req(1'b0, 1'b1, 1'b0, SZ_B, 32'h30000, 32'h5A); settle();
    chk("io_ready", 32'(req_ready), 32'h1);
    for (int j = 0; j < 3; j++) begin
      tick(); clr_req(1'b0); io_buffer_full = 1'b1; settle();
      chk("io_stall_wr", 32'(mem_wr), 32'h0);
      chk("io_stall_a", mem_a, 32'h30000);
    end
    tick(); io_buffer_full = 1'b0; settle();
    chk("io_issue_wr", 32'(mem_wr), 32'h1);
    chk("io_issue_dout", 32'(mem_dout), 32'h5A);
    chk("io_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("io_rv", 32'(resp_valid), 32'h1);

    // Flushed port0 word read; queued port1 byte read accepted after abort
    tick(); set_req(1'b0, 1'b0, 1'b0, SZ_W, 32'h100, 32'h0); settle();
    chk("fl_ready", 32'(req_ready), 32'h1);
    tick(); clr_req(1'b0); set_req(1'b1, 1'b0, 1'b0, SZ_B, 32'h200, 32'h0); settle();
    chk("fl_busy", 32'(req_ready), 32'h0);
    tick(); rob_clear = 1'b1; settle();
    chk("fl_wr", 32'(mem_wr), 32'h0);
    tick(); rob_clear = 1'b0; settle();
    chk("fl_accept1", 32'(req_ready), 32'h2);
    chk("fl_no_rv", 32'(resp_valid), 32'h0);
    tick(); clr_req(1'b1); settle();
    tick(); settle();
    chk("fl_p1_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("fl_p1_rv", 32'(resp_valid), 32'h2);
    chk("fl_p1_data", resp_data, 32'h000000EF);

    // Word write under rob_clear completes fully
    wd = 32'h11223344;
    tick(); rob_clear = 1'b1; set_req(1'b1, 1'b1, 1'b0, SZ_W, 32'h300, wd); settle();
    chk("wfl_ready", 32'(req_ready), 32'h2);
    for (int j = 0; j < 4; j++) begin
      tick(); clr_req(1'b1); settle();
      chk("wfl_a", mem_a, 32'h300 + 32'(j));
      chk("wfl_dout", 32'(mem_dout), 32'(wd[8*j +: 8]));
      chk("wfl_wr", 32'(mem_wr), 32'h1);
    end
    tick(); settle();
    chk("wfl_rv", 32'(resp_valid), 32'h2);

    // Flushable read held off while rob_clear is high; signed half read
    tick(); set_req(1'b0, 1'b0, 1'b1, SZ_H, 32'h200, 32'h0); settle();
    chk("hb_blocked", 32'(req_ready), 32'h0);
    tick(); rob_clear = 1'b0; settle();
    chk("hb_ready", 32'(req_ready), 32'h1);
    tick(); clr_req(1'b0); settle();
    tick(); settle();
    tick(); settle();
    chk("hb_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("hb_rv", 32'(resp_valid), 32'h1);
    chk("hb_data", resp_data, 32'hFFFFBEEF);

    // Oversized read clamps to MAX_BYTES, zero-extended
    tick(); set_req(1'b0, 1'b0, 1'b0, SZ_D, 32'h300, 32'h0); settle();
    chk("cl_ready", 32'(req_ready), 32'h1);
    tick(); clr_req(1'b0); settle();
    for (int j = 0; j < 4; j++) begin
      tick(); settle();
    end
    chk("cl_early", 32'(resp_valid), 32'h0);
    tick(); settle();
    chk("cl_rv", 32'(resp_valid), 32'h1);
    chk("cl_data", resp_data, 32'h11223344);

    // rdy_in low freezes acceptance and issue
    tick(); rdy_in = 1'b0; set_req(1'b0, 1'b1, 1'b0, SZ_B, 32'h600, 32'h77); settle();
    chk("rdy_noaccept", 32'(req_ready), 32'h0);
    tick(); rdy_in = 1'b1; settle();
    chk("rdy_accept", 32'(req_ready), 32'h1);
    tick(); clr_req(1'b0); rdy_in = 1'b0; settle();
    chk("rdy_frozen_wr", 32'(mem_wr), 32'h0);
    tick(); rdy_in = 1'b1; settle();
    chk("rdy_issue_wr", 32'(mem_wr), 32'h1);
    chk("rdy_issue_a", mem_a, 32'h600);
    tick(); settle();
    chk("rdy_rv", 32'(resp_valid), 32'h1);

    // Reset mid-access abandons the write without a completion
    tick(); set_req(1'b1, 1'b1, 1'b0, SZ_W, 32'h500, 32'hCAFEF00D); settle();
    chk("mr_ready", 32'(req_ready), 32'h2);
    tick(); clr_req(1'b1); settle();
    tick(); rst_in = 1'b1; settle();
    tick(); rst_in = 1'b0; settle();
    chk("mr_wr", 32'(mem_wr), 32'h0);
    chk("mr_a", mem_a, 32'h0);
    any_rv = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick(); settle();
      any_rv = any_rv | (|resp_valid);
    end
    chk("mr_no_rv", 32'(any_rv), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_arb.md
# mem_ctrl_arb

Parametrised byte-serial memory controller with an N-port round-robin front end, sitting between the CPU's memory clients (instruction fetch, load/store buffer, …) and the 8-bit external RAM/IO bus. It serialises accesses of 1 to MAX_BYTES bytes, sign- or zero-extends read data, and stalls IO accesses while the UART buffer is full. On a pipeline flush it cancels flushable reads but always completes writes.

## Interface
- NUM_PORTS, 2: number of requesting clients.
- MAX_BYTES, 4: largest access in bytes; power of two, 1..16. DATA_W = 8*MAX_BYTES.
- FLUSH_MASK, 2'b11: bit i set means reads from port i are cancelled by rob_clear.
- clk_in  in  1  system clock; one clock domain.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global enable; low freezes all state.
- rob_clear  in  1  pipeline flush.
- req_valid  in  NUM_PORTS  request present, one bit per port.
- req_write  in  NUM_PORTS  1 = write.
- req_signed  in  NUM_PORTS  1 = sign-extend read data.
- req_size  in  3*NUM_PORTS  log2 of the byte count; values above log2(MAX_BYTES) clamp to MAX_BYTES.
- req_addr  in  32*NUM_PORTS  byte address.
- req_wdata  in  DATA_W*NUM_PORTS  write data, little-endian.
- req_ready  out  NUM_PORTS  one-hot; the request is accepted this cycle.
- resp_valid  out  NUM_PORTS  one-hot single-cycle completion (read data or write ack).
- resp_data  out  DATA_W  extended read data, shared by all ports.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

## Operation
- States: IDLE, RUN, TAIL (reads only).
- IDLE:
  - If any req_valid is high, the round-robin arbiter grants one port. That port's req_ready goes high combinationally.
  - Request fields, the port index, byte count N and byte counter k=0 are latched; the block enters RUN.
  - A read from a port in FLUSH_MASK is not granted while rob_clear is high.
- RUN:
  - Each cycle drives mem_a = addr+k, mem_wr = write and mem_dout = wdata byte k, then increments k.
  - The memory bus outputs are registered.
  - For reads, the byte issued in cycle c is captured from mem_din in cycle c+1 into byte lane c's slot.
  - After byte N-1 is issued: a write goes to IDLE and pulses resp_valid; a read goes to TAIL.
- TAIL: captures the final byte, pulses resp_valid with extended data, returns to IDLE.
- Extension: bytes N..MAX_BYTES-1 of resp_data are replicated from bit 8N-1 if signed, zero otherwise.
- IO stall: when the latched addr[17:16]==2'b11 and io_buffer_full is high in RUN, no byte is issued (mem_wr=0, mem_a holds) and k holds. Capture of an already-issued byte still occurs. Non-IO accesses ignore io_buffer_full.
- Flush: rob_clear in RUN or TAIL during a flushable read drives mem_wr to 0 and returns to IDLE next cycle with no resp_valid. Writes and non-flushable reads are unaffected.
- Round-robin: the pointer is 0 after reset. After a grant to port i, port (i+1) mod NUM_PORTS has highest priority.
- No alignment requirement; addresses increment linearly and wrap at 2^32.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, mem_a=0, mem_dout=0, mem_wr=0, state IDLE, RR pointer 0.
- rdy_in low: mem_wr forced to 0, no state or counter change, req_ready=0.
- Accept in cycle T; bytes issued T+1..T+N.
  - Write: resp_valid in cycle T+N+1.
  - Read: resp_valid in cycle T+N+2.
  - Each IO stall cycle adds 1.
- A new request is accepted no earlier than the cycle after resp_valid, or after the abort cycle.
- Reset mid-access: the access is abandoned and no resp_valid is produced.
- rob_clear together with a non-flushable or write request: the request is accepted normally.

## Configuration
- MEM_CTRL_ARB_PERF_EN defined adds two 32-bit outputs:
  - perf_busy_cycles: counts cycles not in IDLE while rdy_in is high.
  - perf_io_stall_cycles: counts IO stall cycles.
  - Both reset to 0 and wrap.
- MEM_CTRL_ARB_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package mem_ctrl_pkg holds:
  - State enum (IDLE/RUN/TAIL).
  - Size encodings SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3.
  - IO_ADDR_TAG=2'b11.
- Sub-module rr_arbiter: NUM_PORTS-wide round-robin arbiter; inputs request vector and advance strobe, output one-hot grant.

## Test plan
- Port0 signed byte read of 0x80 at 0x100 -> resp_valid[0] at T+3, resp_data=0xFFFFFF80.
- Port1 word write 0xDEADBEEF at 0x200 -> mem_a 0x200..0x203 with mem_dout EF,BE,AD,DE and mem_wr=1; resp_valid[1] at T+5.
- Both ports requesting continuously -> grants alternate 0,1,0,1; no request starves.
- Byte write to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr held 0 for 3 cycles, then issues; resp_valid at T+5.
- Port0 word read with rob_clear at T+2 -> no resp_valid; IDLE at T+3; a queued port1 request is accepted at T+3.
- Word write in progress with rob_clear high -> all 4 bytes written and ack delivered at T+5.
